flip_engine: RTL

FLIP_ENGINE -- requirements
Module: flip_engine

---
 rtl/flip_engine.sv | 200 ++++++++++++++++++++
 1 files changed

// File: rtl/flip_engine.sv
// Resolves one Othello move: scans the eight rays from the placed disc one cell per
// cycle, accumulates captured cells in a flip mask, then writes the updated board.
module flip_engine (
  input  logic         clk,
  input  logic         resetn,
  input  logic         start,
  input  logic [2:0]   x,
  input  logic [2:0]   y,
  input  logic         player_black,
  input  logic [127:0] board_in,
  output logic [127:0] board_out,
  output logic [5:0]   flip_count,
  output logic         legal,
  output logic         busy,
  output logic         done
);

  typedef enum logic [1:0] {StIdle, StScan, StApply} state_e;

  localparam logic [1:0] CellBlack = 2'b11;
  localparam logic [1:0] CellWhite = 2'b10;

  state_e       r_state, w_state_nxt;
  logic [127:0] r_board, w_board_nxt;
  logic [2:0]   r_ox, w_ox_nxt;
  logic [2:0]   r_oy, w_oy_nxt;
  logic         r_black, w_black_nxt;
  logic [3:0]   r_px, w_px_nxt;
  logic [3:0]   r_py, w_py_nxt;
  logic [2:0]   r_dir, w_dir_nxt;
  logic [63:0]  r_pend, w_pend_nxt;
  logic [63:0]  r_mask, w_mask_nxt;
  logic [127:0] r_board_out, w_board_out_nxt;
  logic [5:0]   r_flip_count, w_flip_count_nxt;
  logic         r_legal, w_legal_nxt;
  logic         r_busy, w_busy_nxt;
  logic         r_done, w_done_nxt;

  logic [3:0]   w_dx, w_dy;
  logic [3:0]   w_nx, w_ny;
  logic         w_off;
  logic [5:0]   w_idx;
  logic [1:0]   w_cell;
  logic [1:0]   w_own, w_opp;
  logic [127:0] w_applied;
  logic [5:0]   w_pop;

  // Ray deltas as 4-bit two's complement; 4'b1111 is -1.
  always_comb begin
    w_dx = 4'd0;
    w_dy = 4'd0;
    unique case (r_dir)
      3'd0: begin w_dx = 4'd0;    w_dy = 4'b1111; end
      3'd1: begin w_dx = 4'd1;    w_dy = 4'b1111; end
      3'd2: begin w_dx = 4'd1;    w_dy = 4'd0;    end
      3'd3: begin w_dx = 4'd1;    w_dy = 4'd1;    end
      3'd4: begin w_dx = 4'd0;    w_dy = 4'd1;    end
      3'd5: begin w_dx = 4'b1111; w_dy = 4'd1;    end
      3'd6: begin w_dx = 4'b1111; w_dy = 4'd0;    end
      3'd7: begin w_dx = 4'b1111; w_dy = 4'b1111; end
      default: begin w_dx = 4'd0; w_dy = 4'd0;    end
    endcase
  end

  // Both 8 (7+1) and 15 (0-1) have bit 3 set, so bit 3 flags an off-board step.
  assign w_nx   = r_px + w_dx;
  assign w_ny   = r_py + w_dy;
  assign w_off  = w_nx[3] | w_ny[3];
  assign w_idx  = {w_ny[2:0], w_nx[2:0]};
  assign w_cell = r_board[{w_idx, 1'b0} +: 2];
  assign w_own  = r_black ? CellBlack : CellWhite;
  assign w_opp  = r_black ? CellWhite : CellBlack;

  always_comb begin
    w_applied = r_board;
    w_pop     = 6'd0;
    for (int i = 0; i < 64; i++) begin
      if (r_mask[i]) begin
        w_applied[2*i +: 2] = w_own;
      end
      w_pop = w_pop + 6'(r_mask[i]);
    end
  end

  always_comb begin
    w_state_nxt      = r_state;
    w_board_nxt      = r_board;
    w_ox_nxt         = r_ox;
    w_oy_nxt         = r_oy;
    w_black_nxt      = r_black;
    w_px_nxt         = r_px;
    w_py_nxt         = r_py;
    w_dir_nxt        = r_dir;
    w_pend_nxt       = r_pend;
    w_mask_nxt       = r_mask;
    w_board_out_nxt  = r_board_out;
    w_flip_count_nxt = r_flip_count;
    w_legal_nxt      = r_legal;
    w_busy_nxt       = r_busy;
    w_done_nxt       = 1'b0;

    unique case (r_state)
      StIdle: begin
        if (start) begin
          w_board_nxt = board_in;
          w_ox_nxt    = x;
          w_oy_nxt    = y;
          w_black_nxt = player_black;
          w_px_nxt    = {1'b0, x};
          w_py_nxt    = {1'b0, y};
          w_dir_nxt   = 3'd0;
          w_pend_nxt  = '0;
          w_mask_nxt  = '0;
          w_busy_nxt  = 1'b1;
          w_state_nxt = StScan;
        end
      end
      StScan: begin
        if (!w_off && (w_cell == w_opp)) begin
          w_pend_nxt[w_idx] = 1'b1;
          w_px_nxt          = w_nx;
          w_py_nxt          = w_ny;
        end else begin
          // Ray closed: only an own-colour cap commits the pending run.
          if (!w_off && (w_cell == w_own)) begin
            w_mask_nxt = r_mask | r_pend;
          end
          w_pend_nxt = '0;
          w_px_nxt   = {1'b0, r_ox};
          w_py_nxt   = {1'b0, r_oy};
          w_dir_nxt  = r_dir + 3'd1;
          if (r_dir == 3'd7) begin
            w_state_nxt = StApply;
          end
        end
      end
      StApply: begin
        w_board_out_nxt  = w_applied;
        w_flip_count_nxt = w_pop;
        w_legal_nxt      = (w_pop != 6'd0);
        w_done_nxt       = 1'b1;
        w_busy_nxt       = 1'b0;
        w_state_nxt      = StIdle;
      end
      default: begin
        w_state_nxt = StIdle;
        w_busy_nxt  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_board      <= '0;
      r_ox         <= '0;
      r_oy         <= '0;
      r_black      <= 1'b0;
      r_px         <= '0;
      r_py         <= '0;
      r_dir        <= '0;
      r_pend       <= '0;
      r_mask       <= '0;
      r_board_out  <= '0;
      r_flip_count <= '0;
      r_legal      <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
    end else begin
      r_board      <= w_board_nxt;
      r_ox         <= w_ox_nxt;
      r_oy         <= w_oy_nxt;
      r_black      <= w_black_nxt;
      r_px         <= w_px_nxt;
      r_py         <= w_py_nxt;
      r_dir        <= w_dir_nxt;
      r_pend       <= w_pend_nxt;
      r_mask       <= w_mask_nxt;
      r_board_out  <= w_board_out_nxt;
      r_flip_count <= w_flip_count_nxt;
      r_legal      <= w_legal_nxt;
      r_busy       <= w_busy_nxt;
      r_done       <= w_done_nxt;
    end
  end

  assign board_out  = r_board_out;
  assign flip_count = r_flip_count;
  assign legal      = r_legal;
  assign busy       = r_busy;
  assign done       = r_done;

endmodule
